// File: rtl/reservoir_model.sv
// Reservoir level model: a tick divider paces level updates driven by valve
// commands, with saturating level, thermometer-coded sensors and sticky
// dry/overflow flags. All outputs are registered.
module reservoir_model #(
    parameter int LEVEL_W    = 8,
    parameter int LEVEL_MAX  = 200,
    parameter int T1         = 50,
    parameter int T2         = 100,
    parameter int T3         = 150,
    parameter int TICK_DIV   = 4,
    parameter int OUTFLOW    = 3,
    parameter int FR_UNIT    = 2,
    parameter int DFR_UNIT   = 1,
    parameter int INIT_LEVEL = 0
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               fr2,
    input  logic               fr1,
    input  logic               fr0,
    input  logic               dfr,
    input  logic               clr_flags,
    output logic [2:0]         s,
    output logic [LEVEL_W-1:0] level,
    output logic               dry,
    output logic               overflow
);

    // Three guard bits give headroom for inflow and a sign bit for the deficit.
    localparam int SUM_W = LEVEL_W + 3;
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic signed [SUM_W-1:0] MAX_S    = SUM_W'(LEVEL_MAX);
    localparam logic signed [SUM_W-1:0] OUT_S    = SUM_W'(OUTFLOW);
    localparam logic signed [SUM_W-1:0] FR_S     = SUM_W'(FR_UNIT);
    localparam logic signed [SUM_W-1:0] DFR_S    = SUM_W'(DFR_UNIT);

    // Clamp the signed sum into the legal level range [0, LEVEL_MAX].
    function automatic logic [LEVEL_W-1:0] sat_level(input logic signed [SUM_W-1:0] sum);
        if (sum[SUM_W-1])
            return '0;
        else if (sum > MAX_S)
            return LEVEL_W'(LEVEL_MAX);
        else
            return sum[LEVEL_W-1:0];
    endfunction

    // Thermometer code of a level against the three sensor heights.
    function automatic logic [2:0] therm(input logic [LEVEL_W-1:0] lvl);
        return {(lvl >= LEVEL_W'(T3)), (lvl >= LEVEL_W'(T2)), (lvl >= LEVEL_W'(T1))};
    endfunction

    logic [CNT_W-1:0]        r_cnt;
    logic [LEVEL_W-1:0]      r_level;
    logic [2:0]              r_s;
    logic                    r_dry;
    logic                    r_overflow;

    logic                    w_tick;
    logic [1:0]              w_nvalves;
    logic signed [SUM_W-1:0] w_inflow;
    logic signed [SUM_W-1:0] w_sum;
    logic [LEVEL_W-1:0]      w_new_level;
    logic                    w_ovf_hit;

    assign w_tick    = (r_cnt == CNT_LAST);
    assign w_nvalves = {1'b0, fr0} + {1'b0, fr1} + {1'b0, fr2};

    // Next-level arithmetic: full-width signed sum, then saturate.
    always_comb begin
        w_inflow = FR_S * $signed({{(SUM_W-2){1'b0}}, w_nvalves});
        if (dfr)
            w_inflow = w_inflow + DFR_S;
        w_sum       = $signed({3'b000, r_level}) + w_inflow - OUT_S;
        w_new_level = sat_level(w_sum);
        w_ovf_hit   = (w_sum > MAX_S);
    end

    // Tick divider: counts 0..TICK_DIV-1; reset discards any partial count.
    always_ff @(posedge clk) begin
        if (!resetn)
            r_cnt <= '0;
        else if (w_tick)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

    // Level and sensors update together so the sensors always reflect the level.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_level <= LEVEL_W'(INIT_LEVEL);
            r_s     <= therm(LEVEL_W'(INIT_LEVEL));
        end else if (w_tick) begin
            r_level <= w_new_level;
            r_s     <= therm(w_new_level);
        end
    end

    // Sticky flags: a set condition on a tick takes priority over a clear.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_dry      <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_tick && (w_new_level == '0))
                r_dry <= 1'b1;
            else if (clr_flags)
                r_dry <= 1'b0;

            if (w_tick && w_ovf_hit)
                r_overflow <= 1'b1;
            else if (clr_flags)
                r_overflow <= 1'b0;
        end
    end

    assign level    = r_level;
    assign s        = r_s;
    assign dry      = r_dry;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_reservoir_model.sv
// Bench for reservoir_model with default parameters: a behavioural model pushes
// expected outputs into a scoreboard queue as each vector is driven, and the
// entry is popped and compared after the clock edge. Directed landmark checks
// against fixed constants are mixed in.
module tb_reservoir_model;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       fr2 = 1'b0, fr1 = 1'b0, fr0 = 1'b0, dfr = 1'b0, clr_flags = 1'b0;
    logic [2:0] s;
    logic [7:0] level;
    logic       dry, overflow;

    reservoir_model dut (
        .clk       (clk),
        .resetn    (resetn),
        .fr2       (fr2),
        .fr1       (fr1),
        .fr0       (fr0),
        .dfr       (dfr),
        .clr_flags (clr_flags),
        .s         (s),
        .level     (level),
        .dry       (dry),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] level;
        logic [2:0] s;
        logic       dry;
        logic       ovf;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state
    int   m_cnt   = 0;
    int   m_level = 0;
    bit   m_dry   = 1'b0;
    bit   m_ovf   = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] therm_model(input int l);
        return {(l >= 150), (l >= 100), (l >= 50)};
    endfunction

    // Drive one vector, advance the model, push its expectation, clock, compare.
    task automatic step(input bit rn, input bit f2, input bit f1, input bit f0,
                        input bit d, input bit clr);
        exp_t e;
        int   sum;
        int   nl;
        resetn = rn; fr2 = f2; fr1 = f1; fr0 = f0; dfr = d; clr_flags = clr;
        if (!rn) begin
            m_cnt = 0; m_level = 0; m_dry = 1'b0; m_ovf = 1'b0;
        end else if (m_cnt == 3) begin
            sum = m_level + 2 * (int'(f0) + int'(f1) + int'(f2)) + int'(d) - 3;
            nl  = (sum < 0) ? 0 : ((sum > 200) ? 200 : sum);
            m_level = nl;
            m_cnt   = 0;
            m_dry   = (nl == 0)   ? 1'b1 : (clr ? 1'b0 : m_dry);
            m_ovf   = (sum > 200) ? 1'b1 : (clr ? 1'b0 : m_ovf);
        end else begin
            m_cnt++;
            if (clr) begin
                m_dry = 1'b0;
                m_ovf = 1'b0;
            end
        end
        e.level = 8'(m_level);
        e.s     = therm_model(m_level);
        e.dry   = m_dry;
        e.ovf   = m_ovf;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_val("sb_level", level, e.level);
        check_val("sb_s", s, e.s);
        check_val("sb_dry", dry, e.dry);
        check_val("sb_overflow", overflow, e.ovf);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 1, 1);
        check_val("rst_level", level, 0);
        check_val("rst_s", s, 0);
        check_val("rst_dry", dry, 0);
        check_val("rst_overflow", overflow, 0);

        // All inputs off: level stays at 0, dry from the first tick (edge 4)
        for (int e = 1; e <= 8; e++) begin
            step(1, 0, 0, 0, 0, 0);
            if (e == 3) check_val("idle_dry_e3", dry, 0);
            if (e == 4) check_val("idle_dry_e4", dry, 1);
        end
        check_val("idle_level", level, 0);
        check_val("idle_s", s, 0);

        // Fill with all three valves (+3 per tick)
        step(0, 0, 0, 0, 0, 0);
        for (int e = 1; e <= 136; e++) begin
            step(1, 1, 1, 1, 0, 0);
            if (e == 3)   check_val("fill_lvl_e3", level, 0);
            if (e == 4)   check_val("fill_lvl_e4", level, 3);
            if (e == 67)  check_val("fill_s_e67", s, 3'b000);
            if (e == 68) begin
                check_val("fill_lvl_e68", level, 51);
                check_val("fill_s_e68", s, 3'b001);
            end
            if (e == 136) begin
                check_val("fill_lvl_e136", level, 102);
                check_val("fill_s_e136", s, 3'b011);
            end
        end
        for (int e = 1; e <= 128; e++) step(1, 1, 1, 1, 0, 0);
        check_val("fill_lvl_198", level, 198);
        check_val("fill_ovf_198", overflow, 0);

        // Saturation at the ceiling with dfr added (+4 per tick)
        for (int e = 1; e <= 4; e++) step(1, 1, 1, 1, 1, 0);
        check_val("sat_level", level, 200);
        check_val("sat_overflow", overflow, 1);
        check_val("sat_s", s, 3'b111);
        for (int e = 1; e <= 8; e++) step(1, 1, 1, 1, 1, 0);
        check_val("sat_hold", level, 200);

        // One-cycle fr2 pulse off-tick has no effect on the next tick
        step(1, 1, 0, 0, 0, 0);
        for (int e = 1; e <= 3; e++) step(1, 0, 0, 0, 0, 0);
        check_val("pulse_level", level, 197);

        // clr_flags off-tick clears overflow
        step(1, 0, 0, 0, 0, 1);
        check_val("clr_overflow", overflow, 0);

        // Drain to empty
        for (int i = 0; i < 400 && m_level != 0; i++) step(1, 0, 0, 0, 0, 0);
        check_val("drain_level", level, 0);
        check_val("drain_dry", dry, 1);

        // clr_flags on a tick that re-sets dry: set wins; then off-tick clear works
        for (int i = 0; i < 8 && m_cnt != 3; i++) step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1);
        check_val("clr_tick_dry", dry, 1);
        step(1, 0, 0, 0, 0, 1);
        check_val("clr_offtick_dry", dry, 0);

        // Mid-count reset at level 120, counter 2
        for (int i = 0; i < 400 && m_level < 120; i++) step(1, 1, 1, 1, 0, 0);
        check_val("pre_rst_level", level, 120);
        for (int i = 0; i < 8 && m_cnt != 2; i++) step(1, 1, 1, 1, 0, 0);
        step(0, 1, 1, 1, 0, 0);
        check_val("midrst_level", level, 0);
        check_val("midrst_s", s, 3'b000);
        for (int e = 1; e <= 4; e++) begin
            step(1, 1, 1, 1, 0, 0);
            if (e == 3) check_val("midrst_e3", level, 0);
            if (e == 4) check_val("midrst_e4", level, 3);
        end

        // Random traffic including clears and occasional resets
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 59) != 0,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 11) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reservoir_model.md
RESERVOIR_MODEL -- requirements
Module: reservoir_model

Interface
REQ-001 Parameter LEVEL_W, default 8: width of the water-level register.
REQ-002 Parameter LEVEL_MAX, default 200: saturation ceiling for the level.
REQ-003 Parameters T1/T2/T3, defaults 50/100/150: sensor thresholds, with T1<T2<T3<=LEVEL_MAX.
REQ-004 Parameter TICK_DIV, default 4: clock cycles per level-update tick, with TICK_DIV>=1.
REQ-005 Parameter OUTFLOW, default 3: consumption subtracted per tick.
REQ-006 Parameter FR_UNIT, default 2: inflow per tick for each asserted fr0/fr1/fr2.
REQ-007 Parameter DFR_UNIT, default 1: extra inflow per tick when dfr is asserted.
REQ-008 Parameter INIT_LEVEL, default 0: level loaded on reset, with INIT_LEVEL<=LEVEL_MAX.
REQ-009 clk  input  1  sole clock; all state updates on its rising edge.
REQ-010 resetn  input  1  reset, synchronous and active-low.
REQ-011 fr2, fr1, fr0, dfr  input  1 each  valve commands from the level controller.
REQ-012 clr_flags  input  1  synchronous clear of the sticky flags.
REQ-013 s  output  3  thermometer sensor bits; s[0] is the lowest sensor.
REQ-014 level  output  LEVEL_W  current registered water level.
REQ-015 dry  output  1  sticky flag: level hit 0 on a tick.
REQ-016 overflow  output  1  sticky flag: an unsaturated sum exceeded LEVEL_MAX on a tick.

Function
REQ-017 The tick counter SHALL count 0..TICK_DIV-1 and wrap; tick is asserted on the cycle the count equals TICK_DIV-1.
REQ-018 The counter SHALL restart from 0 on reset, and the first tick SHALL occur on the TICK_DIV-th rising edge after resetn goes high.
REQ-019 On a tick, inflow SHALL be FR_UNIT*(fr0+fr1+fr2) + DFR_UNIT*dfr, sampled on the tick cycle only.
REQ-020 On a tick, sum SHALL be level + inflow - OUTFLOW, computed signed at LEVEL_W+3 bits with no intermediate truncation.
REQ-021 On a tick, the new level SHALL be 0 if sum<0, LEVEL_MAX if sum>LEVEL_MAX, and sum otherwise.
REQ-022 Off-tick, level SHALL hold regardless of input changes.
REQ-023 s SHALL be registered and updated on the same edge as level, so s always matches the current level.
REQ-024 s[0] SHALL be (level>=T1), s[1] SHALL be (level>=T2), and s[2] SHALL be (level>=T3).
REQ-025 s SHALL be one of 000, 001, 011 or 111 in every cycle.
REQ-026 dry SHALL set on any tick whose new level is 0, including a level already at 0.
REQ-027 overflow SHALL set on any tick where sum>LEVEL_MAX.
REQ-028 The flags SHALL clear on the edge after clr_flags=1; if a set condition and clr_flags coincide, the set SHALL win.
REQ-029 Valve inputs SHALL have no combinational path to any output; output latency from inputs is at most TICK_DIV cycles.

Reset
REQ-030 While resetn=0 at a rising edge: level=INIT_LEVEL, tick counter=0, dry=0, overflow=0.
REQ-031 While resetn=0 at a rising edge: s SHALL be the thermometer code of INIT_LEVEL (000 for the defaults).
REQ-032 A reset asserted mid-count SHALL discard the partial count, and no tick SHALL fire on the reset edge.

Verification
REQ-033 Defaults, reset, then all valves on (fr=111, dfr=0, net +3 per tick): level=3 at edge 4 and 51 at edge 68; s=001 from edge 68; s=011 at level 102 (edge 136).
REQ-034 Defaults, reset, then all inputs 0: level stays 0; dry=1 from edge 4; s=000 throughout.
REQ-035 Fill to 198, then all valves plus dfr (net +4): next tick gives level=200, overflow=1, s=111; level holds at 200 on later ticks.
REQ-036 Assert clr_flags on a tick edge that re-sets dry (level 0, no inflow): dry stays 1; clr_flags on a non-tick edge gives dry=0.
REQ-037 Pulse fr2 for one cycle only on a non-tick cycle: level is unchanged at the next tick except for -3 outflow.
REQ-038 Drop resetn for one cycle at counter=2 with level=120: the next edge gives level=0 and s=000, and the next tick occurs 4 edges after release.
